blowfish128_pkey_init: RTL and testbench

Upstream key-schedule stage for blowfish128_core. Accepts a variable-length user key (1..14 words of 32 bits) over a valid/ready stream. Produces the 20-entry P-array by XORing the fixed P-array initial constants with the key words, cycled cyclically. Drives P1..P20 and skey_ready straight into blowfish128_core; the core must not start encryption until skey_ready is high.

---
 rtl/blowfish128_pkg.sv | 30 +++
 rtl/blowfish128_pkey_init.sv | 147 ++++++++++++++
 tb/tb_blowfish128_pkey_init.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/blowfish128_pkg.sv
// Shared definitions for the Blowfish-128 key schedule and core:
// geometry constants, P-array initial constants, FSM states, subkey array type.
package blowfish128_pkg;

  localparam int KEY_WORD_W    = 32;
  localparam int MAX_KEY_WORDS = 14;
  localparam int P_ENTRIES     = 20;
  localparam int KEY_CNT_W     = 4;   // holds 0..MAX_KEY_WORDS
  localparam int MIX_IDX_W     = 5;   // holds 0..P_ENTRIES

  // Subkey array, index 0 = P1.
  typedef logic [0:P_ENTRIES-1][KEY_WORD_W-1:0] subkey_arr_t;

  // Fractional hex digits of pi, indices 0..19.
  localparam subkey_arr_t PINIT = {
    32'h243F6A88, 32'h85A308D3, 32'h13198A2E, 32'h03707344,
    32'hA4093822, 32'h299F31D0, 32'h082EFA98, 32'hEC4E6C89,
    32'h452821E6, 32'h38D01377, 32'hBE5466CF, 32'h34E90C6C,
    32'hC0AC29B7, 32'hC97C50DD, 32'h3F84D5B5, 32'hB5470917,
    32'h9216D5D9, 32'h8979FB1B, 32'h578FDFE3, 32'h3AC372E6
  };

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    MIX   = 2'd2,
    READY = 2'd3
  } state_t;

endpackage

// File: rtl/blowfish128_pkey_init.sv
// Blowfish-128 P-array initialisation: collects a 1..14 word user key over a
// valid/ready stream, then mixes it cyclically into the pi constants, one
// subkey per cycle, and raises skey_ready once all 20 subkeys are written.
module blowfish128_pkey_init
  import blowfish128_pkg::*;
(
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic                  keyValid,
  input  logic [KEY_WORD_W-1:0] keyWord,
  input  logic                  keyLast,
  output logic                  keyReady,
  output logic                  busy,
  output logic                  skey_ready,
  output logic [KEY_WORD_W-1:0] P1,
  output logic [KEY_WORD_W-1:0] P2,
  output logic [KEY_WORD_W-1:0] P3,
  output logic [KEY_WORD_W-1:0] P4,
  output logic [KEY_WORD_W-1:0] P5,
  output logic [KEY_WORD_W-1:0] P6,
  output logic [KEY_WORD_W-1:0] P7,
  output logic [KEY_WORD_W-1:0] P8,
  output logic [KEY_WORD_W-1:0] P9,
  output logic [KEY_WORD_W-1:0] P10,
  output logic [KEY_WORD_W-1:0] P11,
  output logic [KEY_WORD_W-1:0] P12,
  output logic [KEY_WORD_W-1:0] P13,
  output logic [KEY_WORD_W-1:0] P14,
  output logic [KEY_WORD_W-1:0] P15,
  output logic [KEY_WORD_W-1:0] P16,
  output logic [KEY_WORD_W-1:0] P17,
  output logic [KEY_WORD_W-1:0] P18,
  output logic [KEY_WORD_W-1:0] P19,
  output logic [KEY_WORD_W-1:0] P20
);

  state_t                 state_r, state_s;
  logic [KEY_CNT_W-1:0]   count_r;     // words stored; equals key length L during MIX
  logic [KEY_CNT_W-1:0]   key_idx_r;   // i mod L, kept as a wrapping counter
  logic [KEY_CNT_W-1:0]   key_idx_s;
  logic [KEY_CNT_W-1:0]   wr_idx_s;
  logic [MIX_IDX_W-1:0]   mix_idx_r;
  logic [KEY_WORD_W-1:0]  key_r [0:MAX_KEY_WORDS-1];
  subkey_arr_t            p_r;
  logic                   key_ready_r, busy_r, skey_ready_r;
  logic                   accept_s;

  // Next-state, handshake and key-index decode.
  always_comb begin
    state_s   = state_r;
    accept_s  = keyValid & key_ready_r;
    wr_idx_s  = {KEY_CNT_W{1'b0}};
    key_idx_s = key_idx_r + {{(KEY_CNT_W-1){1'b0}}, 1'b1};
    if (key_idx_r == count_r - {{(KEY_CNT_W-1){1'b0}}, 1'b1}) begin
      key_idx_s = {KEY_CNT_W{1'b0}};
    end else begin
      key_idx_s = key_idx_r + {{(KEY_CNT_W-1){1'b0}}, 1'b1};
    end
    case (state_r)
      IDLE, READY: begin
        if (accept_s) begin
          state_s = keyLast ? MIX : LOAD;
        end else begin
          state_s = state_r;
        end
      end
      LOAD: begin
        wr_idx_s = count_r;
        if (accept_s && (keyLast || (count_r == KEY_CNT_W'(MAX_KEY_WORDS - 1)))) begin
          state_s = MIX;
        end else begin
          state_s = LOAD;
        end
      end
      MIX: begin
        if (mix_idx_r == MIX_IDX_W'(P_ENTRIES - 1)) begin
          state_s = READY;
        end else begin
          state_s = MIX;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // State, counters, subkey registers and registered status flags.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_r      <= IDLE;
      count_r      <= {KEY_CNT_W{1'b0}};
      key_idx_r    <= {KEY_CNT_W{1'b0}};
      mix_idx_r    <= {MIX_IDX_W{1'b0}};
      p_r          <= '0;
      key_ready_r  <= 1'b0;
      busy_r       <= 1'b0;
      skey_ready_r <= 1'b0;
    end else begin
      state_r      <= state_s;
      key_ready_r  <= (state_s != MIX);
      busy_r       <= (state_s == LOAD) || (state_s == MIX);
      skey_ready_r <= (state_s == READY);
      if (accept_s) begin
        count_r   <= (state_r == LOAD) ? (count_r + {{(KEY_CNT_W-1){1'b0}}, 1'b1})
                                       : {{(KEY_CNT_W-1){1'b0}}, 1'b1};
        key_idx_r <= {KEY_CNT_W{1'b0}};
        mix_idx_r <= {MIX_IDX_W{1'b0}};
      end else if (state_r == MIX) begin
        p_r[mix_idx_r] <= PINIT[mix_idx_r] ^ key_r[key_idx_r];
        mix_idx_r      <= mix_idx_r + {{(MIX_IDX_W-1){1'b0}}, 1'b1};
        key_idx_r      <= key_idx_s;
      end
    end
  end

  // Key register file: each accepted word lands at its position in the key.
  always_ff @(posedge Clk) begin
    if (accept_s && !Rst) begin
      key_r[wr_idx_s] <= keyWord;
    end
  end

  assign keyReady   = key_ready_r;
  assign busy       = busy_r;
  assign skey_ready = skey_ready_r;

  assign P1  = p_r[0];
  assign P2  = p_r[1];
  assign P3  = p_r[2];
  assign P4  = p_r[3];
  assign P5  = p_r[4];
  assign P6  = p_r[5];
  assign P7  = p_r[6];
  assign P8  = p_r[7];
  assign P9  = p_r[8];
  assign P10 = p_r[9];
  assign P11 = p_r[10];
  assign P12 = p_r[11];
  assign P13 = p_r[12];
  assign P14 = p_r[13];
  assign P15 = p_r[14];
  assign P16 = p_r[15];
  assign P17 = p_r[16];
  assign P18 = p_r[17];
  assign P19 = p_r[18];
  assign P20 = p_r[19];

endmodule

// File: tb/tb_blowfish128_pkey_init.sv
// Bench for blowfish128_pkey_init: a transaction-level model predicts the
// status flags and P-array every cycle; directed cases pin known vectors.
`timescale 1ns/1ps
module tb_blowfish128_pkey_init;

  logic        Clk = 1'b0;
  logic        Rst = 1'b1;
  logic        keyValid = 1'b0;
  logic [31:0] keyWord = 32'h0;
  logic        keyLast = 1'b0;
  logic        keyReady, busy, skey_ready;
  logic [31:0] pd [20];

  int vectors = 0;
  int fails   = 0;

  blowfish128_pkey_init dut (
    .Clk(Clk), .Rst(Rst), .keyValid(keyValid), .keyWord(keyWord), .keyLast(keyLast),
    .keyReady(keyReady), .busy(busy), .skey_ready(skey_ready),
    .P1(pd[0]),   .P2(pd[1]),   .P3(pd[2]),   .P4(pd[3]),   .P5(pd[4]),
    .P6(pd[5]),   .P7(pd[6]),   .P8(pd[7]),   .P9(pd[8]),   .P10(pd[9]),
    .P11(pd[10]), .P12(pd[11]), .P13(pd[12]), .P14(pd[13]), .P15(pd[14]),
    .P16(pd[15]), .P17(pd[16]), .P18(pd[17]), .P19(pd[18]), .P20(pd[19])
  );

  always #5 Clk = ~Clk;

  logic [31:0] pinit [20] = '{
    32'h243F6A88, 32'h85A308D3, 32'h13198A2E, 32'h03707344,
    32'hA4093822, 32'h299F31D0, 32'h082EFA98, 32'hEC4E6C89,
    32'h452821E6, 32'h38D01377, 32'hBE5466CF, 32'h34E90C6C,
    32'hC0AC29B7, 32'hC97C50DD, 32'h3F84D5B5, 32'hB5470917,
    32'h9216D5D9, 32'h8979FB1B, 32'h578FDFE3, 32'h3AC372E6};

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %08h expected %08h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] kq [$];
  logic [31:0] exp_p [20];
  bit   started = 0, loading = 0, mixing = 0, ready = 0, p_known = 0;
  bit   exp_kr = 0, exp_busy = 0, exp_sr = 0;
  int   left = 0;

  // Model update on every rising edge from the inputs presented to it.
  always @(posedge Clk) begin
    if (Rst) begin
      started = 1; loading = 0; mixing = 0; ready = 0; p_known = 1;
      kq.delete();
      for (int i = 0; i < 20; i++) exp_p[i] = 32'h0;
      exp_kr = 0; exp_busy = 0; exp_sr = 0;
    end else if (started) begin
      if (mixing) begin
        left--;
        if (left == 0) begin
          mixing = 0; ready = 1; p_known = 1;
          for (int i = 0; i < 20; i++) exp_p[i] = pinit[i] ^ kq[i % kq.size()];
        end
      end else if (keyValid && exp_kr) begin
        if (!loading) begin
          kq.delete();
          ready = 0;
        end
        kq.push_back(keyWord);
        if (keyLast || kq.size() == 14) begin
          loading = 0; mixing = 1; left = 20; p_known = 0;
        end else begin
          loading = 1;
        end
      end
      exp_kr = !mixing; exp_busy = loading || mixing; exp_sr = ready;
    end
  end

  // Compare process: flags every cycle, P-array whenever its contents are known.
  always @(negedge Clk) begin
    if (started) begin
      check("keyReady", {31'h0, keyReady}, {31'h0, exp_kr});
      check("busy", {31'h0, busy}, {31'h0, exp_busy});
      check("skey_ready", {31'h0, skey_ready}, {31'h0, exp_sr});
      if (p_known) begin
        for (int i = 0; i < 20; i++) check($sformatf("P%0d", i + 1), pd[i], exp_p[i]);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic send_word(input logic [31:0] w, input bit last);
    bit done = 0;
    keyValid = 1'b1; keyWord = w; keyLast = last;
    for (int t = 0; t < 200 && !done; t++) begin
      @(negedge Clk);
      if (keyReady) begin
        @(posedge Clk); #1;
        done = 1;
      end
    end
    keyValid = 1'b0; keyLast = 1'b0;
    if (!done) begin
      vectors++; fails++;
      $display("FAIL handshake_timeout: word %08h not accepted within 200 cycles", w);
    end
  endtask

  // Counts edges from now until skey_ready; expects exactly 20.
  task automatic check_latency(input string nm);
    int n = 0;
    while (!skey_ready && n < 60) begin
      @(posedge Clk); #1; n++;
    end
    check(nm, n, 32'd20);
  endtask

  task automatic pulse_reset();
    Rst = 1'b1; @(posedge Clk); #1; Rst = 1'b0;
  endtask

  logic [31:0] w1;

  initial begin
    repeat (2) @(posedge Clk); #1;
    Rst = 1'b0;
    check("reset_P1", pd[0], 32'h0);
    check("reset_keyReady", {31'h0, keyReady}, 32'h0);

    // 64-bit key: known vector
    send_word(32'hAABB0918, 1'b0);
    send_word(32'h2736CCDD, 1'b1);
    check_latency("lat_64bit");
    check("lit_P1", pd[0], 32'h8E846390);
    check("lit_P2", pd[1], 32'hA295C40E);
    check("lit_P3", pd[2], 32'hB9A28336);
    check("lit_P4", pd[3], 32'h2446BF99);
    check("lit_P17", pd[16], 32'h38ADDCC1);
    check("lit_P18", pd[17], 32'hAE4F37C6);
    check("lit_P19", pd[18], 32'hFD34D6FB);
    check("lit_P20", pd[19], 32'h1DF5BE3B);
    check("model_P1", exp_p[0], 32'h8E846390);
    check("model_P20", exp_p[19], 32'h1DF5BE3B);

    // Rekey from READY with a single all-ones word
    send_word(32'hFFFFFFFF, 1'b1);
    check("rekey_sr_clear", {31'h0, skey_ready}, 32'h0);
    check_latency("lat_rekey");
    check("lit_rekey_P1", pd[0], 32'hDBC09577);

    // Single zero word: P equals the constants
    send_word(32'h00000000, 1'b1);
    check_latency("lat_L1");
    check("lit_zero_P1", pd[0], 32'h243F6A88);
    check("lit_zero_P20", pd[19], 32'h3AC372E6);

    // 15 words with keyLast never set: load stops at 14
    w1 = $urandom;
    send_word(w1, 1'b0);
    for (int j = 1; j < 14; j++) send_word($urandom, 1'b0);
    check("kr_after14", {31'h0, keyReady}, 32'h0);
    check_latency("lat_L14");
    check("lit_P1_L14", pd[0], 32'h243F6A88 ^ w1);
    check("lit_P15_L14", pd[14], 32'h3F84D5B5 ^ w1);
    send_word($urandom, 1'b0);            // word 15 starts a rekey
    send_word($urandom, 1'b1);
    check_latency("lat_after15");

    // Gaps of 3 idle cycles between words
    for (int j = 0; j < 5; j++) begin
      send_word($urandom, j == 4);
      if (j != 4) repeat (3) @(posedge Clk);
      #1;
    end
    check_latency("lat_gaps");

    // Reset during MIX after P5 has been written
    send_word($urandom, 1'b0);
    send_word($urandom, 1'b0);
    send_word($urandom, 1'b1);
    repeat (5) @(posedge Clk); #1;
    pulse_reset();
    check("mixrst_P5", pd[4], 32'h0);
    check("mixrst_busy", {31'h0, busy}, 32'h0);
    send_word(32'h01234567, 1'b0);
    send_word(32'h89ABCDEF, 1'b1);
    check_latency("lat_after_rst");
    check("lit_after_rst_P1", pd[0], 32'h243F6A88 ^ 32'h01234567);

    // Randomised keys of random length with random gaps
    for (int k = 0; k < 25; k++) begin
      int len;
      len = $urandom_range(1, 16);
      for (int j = 0; j < len && j < 14; j++) begin
        repeat ($urandom_range(0, 2)) @(posedge Clk);
        #1;
        send_word($urandom, j == len - 1);
      end
      check_latency($sformatf("lat_rand%0d", k));
      repeat ($urandom_range(0, 3)) @(posedge Clk);
      #1;
    end

    @(negedge Clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
